// File: rtl/rca_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// rca_share_arbiter_if
// Bundles the requester side and response side of rca_share_arbiter.
//
// Handshake rules (both channels are strict valid/ready):
//   - Request k transfers on a rising edge where i_req_valid[k] and
//     o_req_ready[k] are both high. Operands only need to be valid in
//     that cycle. Valid may drop before a grant; ready never depends on
//     anything other than the current valid bits, rr_ptr and state.
//   - A response transfers on a rising edge where o_rsp_valid and
//     i_rsp_ready are both high. id/result hold steady while valid waits.
//
// Signals:
//   i_req_valid  [NUM_REQ]        per-requester request valid
//   i_req_a/b    [NUM_REQ*WIDTH]  operands, requester k at [k*WIDTH +: WIDTH]
//   o_req_ready  [NUM_REQ]        one-hot accept, only in IDLE
//   o_rsp_valid                   result valid
//   o_rsp_id     [ID_W]           owner of the result
//   o_rsp_result [WIDTH+1]        {carry_out, sum}
//   i_rsp_ready                   consumer accepts result
//   o_busy                        state is not IDLE
//   o_dbg_state  [2]              FSM state encoding (0 IDLE, 1 ADD, 2 RESP)
//   o_dbg_rr_ptr [ID_W]           round-robin search start
// Modports: master = requester/consumer side, slave = arbiter.
// ---------------------------------------------------------------------------
interface rca_share_arbiter_if #(
   parameter int WIDTH   = 23,
   parameter int NUM_REQ = 4
);
   localparam int ID_W = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       i_req_valid;
   logic [NUM_REQ*WIDTH-1:0] i_req_a;
   logic [NUM_REQ*WIDTH-1:0] i_req_b;
   logic [NUM_REQ-1:0]       o_req_ready;
   logic                     o_rsp_valid;
   logic [ID_W-1:0]          o_rsp_id;
   logic [WIDTH:0]           o_rsp_result;
   logic                     i_rsp_ready;
   logic                     o_busy;
   logic [1:0]               o_dbg_state;
   logic [ID_W-1:0]          o_dbg_rr_ptr;

   modport master (
      output i_req_valid, i_req_a, i_req_b, i_rsp_ready,
      input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result, o_busy,
             o_dbg_state, o_dbg_rr_ptr
   );

   modport slave (
      input  i_req_valid, i_req_a, i_req_b, i_rsp_ready,
      output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result, o_busy,
             o_dbg_state, o_dbg_rr_ptr
   );
endinterface

// File: rtl/rca_share_arbiter.sv
// ---------------------------------------------------------------------------
// rca_share_arbiter
// Round-robin arbiter that time-multiplexes one ripple-carry adder between
// NUM_REQ requesters. Sequence per transaction: IDLE (grant + latch
// operands) -> ADD (ripple chain settles on registered operands, result
// registered) -> RESP (hold result until consumer accepts).
//
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset
//   bus    rca_share_arbiter_if.slave (request, response, busy, debug)
// ---------------------------------------------------------------------------
module rca_share_arbiter #(
   parameter int WIDTH   = 23,
   parameter int NUM_REQ = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   rca_share_arbiter_if.slave   bus
);
   localparam int ID_W = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_gnt_id;
   logic [WIDTH-1:0]  r_op_a;
   logic [WIDTH-1:0]  r_op_b;
   logic [WIDTH:0]    r_result;
   logic              r_rsp_valid;

   logic              w_found;
   logic              w_hi_found;
   logic [ID_W-1:0]   w_lo_idx;
   logic [ID_W-1:0]   w_hi_idx;
   logic [ID_W-1:0]   w_winner;
   logic [WIDTH-1:0]  w_sel_a;
   logic [WIDTH-1:0]  w_sel_b;
   logic              w_accept;
   logic              w_rsp_done;
   logic [ID_W-1:0]   w_ptr_nxt;
   logic [NUM_REQ-1:0] w_ready;

   // Round-robin search: the lowest valid index at or above rr_ptr wins;
   // if none exists the search wraps, so the lowest valid index overall wins.
   // Descending loops leave the lowest matching index as the last write.
   always_comb begin
      w_found    = |bus.i_req_valid;
      w_hi_found = 1'b0;
      w_lo_idx   = '0;
      w_hi_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.i_req_valid[k]) begin
            w_lo_idx = ID_W'(k);
            if (k >= int'(r_rr_ptr)) begin
               w_hi_idx   = ID_W'(k);
               w_hi_found = 1'b1;
            end
         end
      end
      w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
   end

   // Operand mux for the winning requester.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (ID_W'(k) == w_winner) begin
            w_sel_a = bus.i_req_a[k*WIDTH +: WIDTH];
            w_sel_b = bus.i_req_b[k*WIDTH +: WIDTH];
         end
      end
   end

   // Shared ripple-carry adder: a chain of full adders, carry-in tied to 0.
   // It only ever sees registered operands, so the whole ripple path gets
   // the ADD cycle to settle.
   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH:0]   w_add_result;

   assign w_carry[0] = 1'b0;
   for (genvar g = 0; g < WIDTH; g++) begin : g_fa
      assign w_sum[g]     = r_op_a[g] ^ r_op_b[g] ^ w_carry[g];
      assign w_carry[g+1] = (r_op_a[g] & r_op_b[g]) |
                            (w_carry[g] & (r_op_a[g] ^ r_op_b[g]));
   end
   assign w_add_result = {w_carry[WIDTH], w_sum};

   assign w_ptr_nxt = (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;

   // FSM next state and strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = '0;
      w_accept    = 1'b0;
      w_rsp_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Ready is gated by reset so nothing looks accepted while
            // the block is held in reset.
            if (w_found && !i_rst) begin
               w_ready     = NUM_REQ'(1) << w_winner;
               w_accept    = 1'b1;
               w_state_nxt = S_ADD;
            end
         end
         S_ADD: begin
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (bus.i_rsp_ready) begin
               w_rsp_done  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rr_ptr    <= '0;
         r_gnt_id    <= '0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_result    <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_gnt_id <= w_winner;
         end
         if (r_state == S_ADD) begin
            r_result    <= w_add_result;
            r_rsp_valid <= 1'b1;
         end
         // rr_ptr moves only when a response completes, which bounds the
         // wait of a continuously requesting client to NUM_REQ-1 turns.
         if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= w_ptr_nxt;
         end
      end
   end

   assign bus.o_req_ready  = w_ready;
   assign bus.o_rsp_valid  = r_rsp_valid;
   assign bus.o_rsp_id     = r_gnt_id;
   assign bus.o_rsp_result = r_result;
   assign bus.o_busy       = (r_state != S_IDLE);
   assign bus.o_dbg_state  = r_state;
   assign bus.o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_rca_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rca_share_arbiter
// Directed, table-driven bench for rca_share_arbiter (WIDTH=23, NUM_REQ=4),
// plus hand-written sequences for backpressure and reset in ADD.
// ---------------------------------------------------------------------------
module tb_rca_share_arbiter;
   localparam int WIDTH   = 23;
   localparam int NUM_REQ = 4;
   localparam int BW      = NUM_REQ * WIDTH;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rca_share_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

   rca_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [WIDTH:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] pack4(input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] x1,
                                           input logic [WIDTH-1:0] x2, input logic [WIDTH-1:0] x3);
      return {x3, x2, x1, x0};
   endfunction

   typedef struct {
      string          name;
      logic [3:0]     valid;
      logic [BW-1:0]  a_bus;
      logic [BW-1:0]  b_bus;
      int             exp_id;
      logic [WIDTH:0] exp_res;
   } vec_t;

   vec_t vecs[13];

   // ---------------- driver ----------------
   // Starts just after a falling edge with the DUT in IDLE and i_rsp_ready
   // high; ends just after the falling edge back in IDLE.
   task automatic do_txn(input vec_t v);
      logic [WIDTH:0] e;
      bus.i_req_valid = v.valid;
      bus.i_req_a     = v.a_bus;
      bus.i_req_b     = v.b_bus;
      #1;
      chk({v.name, " ready"}, 64'(bus.o_req_ready), 64'(1) << v.exp_id);
      chk({v.name, " idle_busy"}, 64'(bus.o_busy), 64'd0);
      exp_q.push_back(v.exp_res);
      @(posedge clk);
      #1;
      // Operands only matter in the accept cycle.
      bus.i_req_a = BW'({$urandom(), $urandom(), $urandom()});
      bus.i_req_b = BW'({$urandom(), $urandom(), $urandom()});
      @(negedge clk);
      chk({v.name, " add_valid"}, 64'(bus.o_rsp_valid), 64'd0);
      chk({v.name, " add_busy"}, 64'(bus.o_busy), 64'd1);
      chk({v.name, " add_ready"}, 64'(bus.o_req_ready), 64'd0);
      chk({v.name, " add_state"}, 64'(bus.o_dbg_state), 64'd1);
      @(negedge clk);
      e = exp_q.pop_front();
      chk({v.name, " rsp_valid"}, 64'(bus.o_rsp_valid), 64'd1);
      chk({v.name, " rsp_id"}, 64'(bus.o_rsp_id), 64'(v.exp_id));
      chk({v.name, " rsp_result"}, 64'(bus.o_rsp_result), 64'(e));
      chk({v.name, " rsp_ready"}, 64'(bus.o_req_ready), 64'd0);
      @(negedge clk);
      chk({v.name, " done_valid"}, 64'(bus.o_rsp_valid), 64'd0);
      chk({v.name, " done_busy"}, 64'(bus.o_busy), 64'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- test ----------------
   logic [BW-1:0] rr_a, rr_b;

   initial begin
      rr_a = pack4(23'h000123, 23'h400000, 23'h155555, 23'h7FFFFE);
      rr_b = pack4(23'h000456, 23'h400000, 23'h2AAAAA, 23'h000003);

      vecs[0]  = '{"single_r2", 4'b0100, pack4(23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF),
                   pack4(23'h7FFFFF, 23'h7FFFFF, 23'h000001, 23'h7FFFFF), 2, 24'h800000};
      vecs[1]  = '{"max_r0", 4'b0001, pack4(23'h7FFFFF, 23'h0, 23'h0, 23'h0),
                   pack4(23'h7FFFFF, 23'h0, 23'h0, 23'h0), 0, 24'hFFFFFE};
      vecs[2]  = '{"zero_r1", 4'b0010, pack4(23'h7FFFFF, 23'h0, 23'h7FFFFF, 23'h7FFFFF),
                   pack4(23'h7FFFFF, 23'h0, 23'h7FFFFF, 23'h7FFFFF), 1, 24'h000000};
      vecs[3]  = '{"only_r3", 4'b1000, rr_a, rr_b, 3, 24'h800001};
      vecs[4]  = '{"all_0", 4'b1111, rr_a, rr_b, 0, 24'h000579};
      vecs[5]  = '{"all_1", 4'b1111, rr_a, rr_b, 1, 24'h800000};
      vecs[6]  = '{"all_2", 4'b1111, rr_a, rr_b, 2, 24'h3FFFFF};
      vecs[7]  = '{"all_3", 4'b1111, rr_a, rr_b, 3, 24'h800001};
      vecs[8]  = '{"all_wrap0", 4'b1111, rr_a, rr_b, 0, 24'h000579};
      // Fairness run, entered with rr_ptr = 3.
      vecs[9]  = '{"fair_r0a", 4'b0001, rr_a, rr_b, 0, 24'h000579};
      vecs[10] = '{"fair_r3", 4'b1001, rr_a, rr_b, 3, 24'h800001};
      vecs[11] = '{"fair_r0b", 4'b0001, rr_a, rr_b, 0, 24'h000579};
      // First transaction after reset in ADD.
      vecs[12] = '{"post_rst", 4'b1111, rr_a, rr_b, 0, 24'h000579};

      // Reset: ready must stay low even with every valid bit set.
      rst             = 1'b1;
      bus.i_req_valid = 4'b1111;
      bus.i_req_a     = rr_a;
      bus.i_req_b     = rr_b;
      bus.i_rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst ready", 64'(bus.o_req_ready), 64'd0);
      chk("rst rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
      chk("rst rsp_id", 64'(bus.o_rsp_id), 64'd0);
      chk("rst rsp_result", 64'(bus.o_rsp_result), 64'd0);
      chk("rst busy", 64'(bus.o_busy), 64'd0);
      chk("rst rr_ptr", 64'(bus.o_dbg_rr_ptr), 64'd0);
      rst             = 1'b0;
      bus.i_req_valid = '0;
      bus.i_rsp_ready = 1'b1;
      @(negedge clk);

      for (int i = 0; i <= 8; i++) do_txn(vecs[i]);
      chk("after_table rr_ptr", 64'(bus.o_dbg_rr_ptr), 64'd1);

      // Backpressure: requester 2 result held for 5 cycles, others requesting.
      bus.i_rsp_ready = 1'b0;
      bus.i_req_valid = 4'b0100;
      bus.i_req_a     = pack4(23'h0, 23'h0, 23'h0ABCDE, 23'h0);
      bus.i_req_b     = pack4(23'h0, 23'h0, 23'h054321, 23'h0);
      #1;
      chk("bp accept_ready", 64'(bus.o_req_ready), 64'b0100);
      @(posedge clk);
      #1;
      bus.i_req_valid = 4'b1111;
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         chk("bp hold_valid", 64'(bus.o_rsp_valid), 64'd1);
         chk("bp hold_id", 64'(bus.o_rsp_id), 64'd2);
         chk("bp hold_result", 64'(bus.o_rsp_result), 64'h0FFFFF);
         chk("bp hold_ready", 64'(bus.o_req_ready), 64'd0);
         chk("bp hold_busy", 64'(bus.o_busy), 64'd1);
         @(negedge clk);
      end
      bus.i_rsp_ready = 1'b1;
      bus.i_req_valid = '0;
      @(negedge clk);
      chk("bp done_valid", 64'(bus.o_rsp_valid), 64'd0);
      chk("bp done_busy", 64'(bus.o_busy), 64'd0);
      chk("bp rr_ptr", 64'(bus.o_dbg_rr_ptr), 64'd3);
      bus.i_req_valid = 4'b1111;
      #1;
      chk("bp next_ready", 64'(bus.o_req_ready), 64'b1000);
      bus.i_req_valid = '0;
      @(negedge clk);

      for (int i = 9; i <= 11; i++) do_txn(vecs[i]);
      chk("fair rr_ptr", 64'(bus.o_dbg_rr_ptr), 64'd1);

      // Reset asserted asynchronously in the middle of ADD.
      bus.i_req_valid = 4'b0010;
      bus.i_req_a     = pack4(23'h0, 23'h000005, 23'h0, 23'h0);
      bus.i_req_b     = pack4(23'h0, 23'h000006, 23'h0, 23'h0);
      #1;
      chk("rstadd accept_ready", 64'(bus.o_req_ready), 64'b0010);
      @(posedge clk);
      @(negedge clk);
      chk("rstadd in_add", 64'(bus.o_dbg_state), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rstadd rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
      chk("rstadd busy", 64'(bus.o_busy), 64'd0);
      chk("rstadd ready", 64'(bus.o_req_ready), 64'd0);
      chk("rstadd rsp_id", 64'(bus.o_rsp_id), 64'd0);
      chk("rstadd rsp_result", 64'(bus.o_rsp_result), 64'd0);
      chk("rstadd state", 64'(bus.o_dbg_state), 64'd0);
      chk("rstadd rr_ptr", 64'(bus.o_dbg_rr_ptr), 64'd0);
      @(negedge clk);
      rst             = 1'b0;
      bus.i_req_valid = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rstadd no_rsp", 64'(bus.o_rsp_valid), 64'd0);
      end
      do_txn(vecs[12]);

      chk("sb empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
